// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sharing one Booth multiplier core among NREQ requesters.
// Define BOOTH_ARB_TIMEOUT_EN to bound the WAIT state to TIMEOUT cycles (rsp_err_o flags expiry).
module booth_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [NREQ-1:0]         req_valid_i,
  input  logic [NREQ*W-1:0]       req_a_i,
  input  logic [NREQ*W-1:0]       req_b_i,
  output logic [NREQ-1:0]         req_ready_o,
  output logic                    rsp_valid_o,
  output logic [$clog2(NREQ)-1:0] rsp_id_o,
  output logic [2*W-1:0]          rsp_product_o,
  output logic                    rsp_err_o,
  output logic                    mul_start_o,
  output logic [W-1:0]            mul_a_o,
  output logic [W-1:0]            mul_b_o,
  input  logic                    mul_done_i,
  input  logic [2*W-1:0]          mul_product_i,
  output logic                    busy_o
);

  // state | meaning
  // IDLE  | no operation; round-robin grant of any pending request
  // START | operands latched, start pulse issued to the core
  // WAIT  | waiting for mul_done_i (bounded when the timeout is built in)
  // RESP  | product latched; response strobe issued, pointer advanced
  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_e;

  state_e          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  gnt_q;
  logic [IDW-1:0]  gnt_d;
  logic [IDW-1:0]  cand;
  logic            gnt_found;
  logic [NREQ-1:0] req_ready_q;
  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [2*W-1:0]  rsp_product_q;
  logic            mul_start_q;
  logic [W-1:0]    mul_a_q;
  logic [W-1:0]    mul_b_q;
  logic            busy_q;

  if (NREQ < 2 || NREQ > 8 || (NREQ & (NREQ - 1)) != 0 || W < 2 || TIMEOUT < 1) begin : g_cfg_err
    $error("booth_mul_arbiter: unsupported parameter set");
  end

`ifdef BOOTH_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_q;
  logic          rsp_err_q;
  assign rsp_err_o = rsp_err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

  // NREQ is a power of two, so the modulo wrap is plain index truncation
  always_comb begin
    gnt_found = 1'b0;
    gnt_d     = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr_q + IDW'(k);
      if (!gnt_found && req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_d     = cand;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      gnt_q         <= '0;
      req_ready_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
      mul_start_q   <= 1'b0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      busy_q        <= 1'b0;
`ifdef BOOTH_ARB_TIMEOUT_EN
      tmo_q         <= '0;
      rsp_err_q     <= 1'b0;
`endif
    end else begin
      req_ready_q <= '0;
      mul_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_found) begin
            state_q     <= START;
            gnt_q       <= gnt_d;
            req_ready_q <= {{(NREQ-1){1'b0}}, 1'b1} << gnt_d;
            mul_a_q     <= req_a_i[gnt_d*W +: W];
            mul_b_q     <= req_b_i[gnt_d*W +: W];
            busy_q      <= 1'b1;
          end
        end
        START: begin
          state_q     <= WAIT;
          mul_start_q <= 1'b1;
`ifdef BOOTH_ARB_TIMEOUT_EN
          tmo_q       <= CW'(TIMEOUT - 1);
`endif
        end
        WAIT: begin
          if (mul_done_i) begin
            state_q       <= RESP;
            rsp_product_q <= mul_product_i;
`ifdef BOOTH_ARB_TIMEOUT_EN
            rsp_err_q     <= 1'b0;
          end else if (tmo_q == '0) begin
            state_q       <= RESP;
            rsp_product_q <= '0;
            rsp_err_q     <= 1'b1;
          end else begin
            tmo_q         <= tmo_q - CW'(1);
`endif
          end
        end
        RESP: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b1;
          rsp_id_q    <= gnt_q;
          ptr_q       <= gnt_q + IDW'(1);
          busy_q      <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o   = req_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_id_o      = rsp_id_q;
  assign rsp_product_o = rsp_product_q;
  assign mul_start_o   = mul_start_q;
  assign mul_a_o       = mul_a_q;
  assign mul_b_o       = mul_b_q;
  assign busy_o        = busy_q;

endmodule
